// File: rtl/db_ram_1p_arb_pkg.sv
// Shared encodings for the deblocking SRAM arbiter: FSM states and the
// request/grant bit positions used by the round-robin picker.
package db_ram_1p_arb_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } arb_st_e;

    localparam int GNT_WR = 0;
    localparam int GNT_RD = 1;

endpackage

// File: rtl/db_ram_1p_arb_rr.sv
// 2-way round-robin picker for the SRAM arbiter; owns the last-grant flop.
// Grant is one-hot or zero, and zero whenever en is low.
module db_ram_arb_rr
    import db_ram_1p_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // 1 means the previous transfer went to RD
    logic last_rd_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                if (last_rd_q) gnt[GNT_WR] = 1'b1;
                else           gnt[GNT_RD] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        last_rd_q <= 1'b0;
        else if (|gnt)  last_rd_q <= gnt[GNT_RD];
    end

endmodule

// File: rtl/db_ram_1p_arb.sv
// Single-port SRAM arbiter/sequencer for the deblocking filter.
// Define DB_RAM_ARB_INIT_EN to build the INIT_VAL fill sweep.
module db_ram_1p_arb
    import db_ram_1p_arb_pkg::*;
#(
    parameter int                    WORD_WIDTH = 20,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_val_i,
    output logic                  wr_rdy_o,
    input  logic [ADDR_WIDTH-1:0] wr_adr_i,
    input  logic [WORD_WIDTH-1:0] wr_dat_i,
    input  logic                  rd_val_i,
    output logic                  rd_rdy_o,
    input  logic [ADDR_WIDTH-1:0] rd_adr_i,
    output logic                  rd_vld_o,
    output logic [WORD_WIDTH-1:0] rd_dat_o,
    input  logic                  init_i,
    output logic                  init_bsy_o,
    output logic                  init_done_o,
    output logic                  cen_o,
    output logic                  oen_o,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [WORD_WIDTH-1:0] dat_o,
    input  logic [WORD_WIDTH-1:0] dat_i
);

    logic [1:0]            req, gnt;
    logic                  arb_en;
    logic                  sweep;
    logic [ADDR_WIDTH-1:0] sweep_adr;
    logic [WORD_WIDTH-1:0] sweep_dat;
    logic                  rd_vld_q;

    assign req[GNT_WR] = wr_val_i;
    assign req[GNT_RD] = rd_val_i;

`ifdef DB_RAM_ARB_INIT_EN
    arb_st_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (init_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign arb_en      = !rst && (state_q == ST_RUN);
    assign sweep       = !rst && (state_q == ST_INIT);
    assign sweep_adr   = cnt_q;
    assign sweep_dat   = INIT_VAL;
    assign init_bsy_o  = (state_q == ST_INIT);
    assign init_done_o = done_q;
`else
    logic unused_init;
    assign unused_init = &{1'b0, init_i, INIT_VAL};

    assign arb_en      = !rst;
    assign sweep       = 1'b0;
    assign sweep_adr   = '0;
    assign sweep_dat   = '0;
    assign init_bsy_o  = 1'b0;
    assign init_done_o = 1'b0;
`endif

    db_ram_arb_rr u_rr (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign wr_rdy_o = gnt[GNT_WR];
    assign rd_rdy_o = gnt[GNT_RD];

    // Sweep and grants are mutually exclusive, so priority order is immaterial
    always_comb begin
        cen_o = 1'b1;
        wen_o = 1'b1;
        adr_o = '0;
        dat_o = '0;
        if (sweep) begin
            cen_o = 1'b0;
            wen_o = 1'b0;
            adr_o = sweep_adr;
            dat_o = sweep_dat;
        end else if (gnt[GNT_WR]) begin
            cen_o = 1'b0;
            wen_o = 1'b0;
            adr_o = wr_adr_i;
            dat_o = wr_dat_i;
        end else if (gnt[GNT_RD]) begin
            cen_o = 1'b0;
            adr_o = rd_adr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_vld_q <= 1'b0;
        else     rd_vld_q <= gnt[GNT_RD];
    end

    // A reset landing on the result cycle must suppress the stale valid
    assign rd_vld_o = rd_vld_q && !rst;
    assign rd_dat_o = dat_i;
    assign oen_o    = 1'b0;

endmodule

// File: tb/tb_db_ram_1p_arb.sv
// Scoreboard bench for db_ram_1p_arb: expected SRAM accesses and read data
// are queued by the stimulus and checked by an independent monitor.
module tb_db_ram_1p_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_val_i = 1'b0, rd_val_i = 1'b0, init_i = 1'b0;
    logic [7:0]  wr_adr_i = '0, rd_adr_i = '0;
    logic [19:0] wr_dat_i = '0;
    logic        wr_rdy_o, rd_rdy_o, rd_vld_o, init_bsy_o, init_done_o;
    logic        cen_o, oen_o, wen_o;
    logic [7:0]  adr_o;
    logic [19:0] rd_dat_o, dat_o, dat_i;

    always #5 clk = ~clk;

    db_ram_1p_arb dut (
        .clk(clk), .rst(rst),
        .wr_val_i(wr_val_i), .wr_rdy_o(wr_rdy_o), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
        .rd_val_i(rd_val_i), .rd_rdy_o(rd_rdy_o), .rd_adr_i(rd_adr_i),
        .rd_vld_o(rd_vld_o), .rd_dat_o(rd_dat_o),
        .init_i(init_i), .init_bsy_o(init_bsy_o), .init_done_o(init_done_o),
        .cen_o(cen_o), .oen_o(oen_o), .wen_o(wen_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i)
    );

    // Behavioural single-port SRAM, one-cycle read latency
    logic [19:0] mem [256];
    logic [19:0] sram_q = '0;
    always @(posedge clk) begin
        if (!cen_o) begin
            if (!wen_o) mem[adr_o] <= dat_o;
            else        sram_q     <= mem[adr_o];
        end
    end
    assign dat_i = sram_q;

    typedef struct {
        logic        wen;
        logic [7:0]  adr;
        logic [19:0] dat;
    } acc_t;

    acc_t        exp_acc[$];
    logic [19:0] exp_rd[$];
    int          checks = 0, errors = 0;
    int          done_cnt = 0, bsy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic acc_t mk(input logic wen, input logic [7:0] adr, input logic [19:0] dat);
        acc_t a;
        a.wen = wen; a.adr = adr; a.dat = dat;
        return a;
    endfunction

    // Monitor: pops and compares whenever the DUT touches the SRAM or returns data
    always @(negedge clk) begin
        if (!rst) begin
            if (!cen_o) begin
                if (exp_acc.size() == 0) chk("unexpected_access", {24'd0, adr_o}, 32'hFFFF_FFFF);
                else begin
                    acc_t a;
                    a = exp_acc.pop_front();
                    chk("acc_wen", {31'd0, wen_o}, {31'd0, a.wen});
                    chk("acc_adr", {24'd0, adr_o}, {24'd0, a.adr});
                    if (!a.wen) chk("acc_dat", {12'd0, dat_o}, {12'd0, a.dat});
                end
            end
            if (rd_vld_o) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_vld", {12'd0, rd_dat_o}, 32'hFFFF_FFFF);
                else chk("rd_dat", {12'd0, rd_dat_o}, {12'd0, exp_rd.pop_front()});
            end
            if (init_done_o) done_cnt++;
            if (init_bsy_o)  bsy_cnt++;
        end
    end

    task automatic do_wr(input logic [7:0] adr, input logic [19:0] dat);
        int n = 0;
        exp_acc.push_back(mk(1'b0, adr, dat));
        wr_val_i = 1'b1; wr_adr_i = adr; wr_dat_i = dat;
        forever begin
            @(negedge clk);
            if (wr_rdy_o) break;
            if (++n > 400) begin chk("wr_rdy_timeout", 32'd0, 32'd1); break; end
        end
        @(posedge clk); #1;
        wr_val_i = 1'b0;
    endtask

    task automatic do_rd(input logic [7:0] adr, input logic [19:0] exp);
        int n = 0;
        exp_acc.push_back(mk(1'b1, adr, '0));
        exp_rd.push_back(exp);
        rd_val_i = 1'b1; rd_adr_i = adr;
        forever begin
            @(negedge clk);
            if (rd_rdy_o) break;
            if (++n > 400) begin chk("rd_rdy_timeout", 32'd0, 32'd1); break; end
        end
        @(posedge clk); #1;
        rd_val_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (exp_acc.size() != 0 || exp_rd.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain_acc", exp_acc.size(), 32'd0);
        chk("drain_rd", exp_rd.size(), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

`ifdef DB_RAM_ARB_INIT_EN
    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) exp_acc.push_back(mk(1'b0, i[7:0], 20'h0));
    endtask

    task automatic wait_sweep_end();
        int n = 0;
        while (init_bsy_o && n < 400) begin @(posedge clk); n++; end
        #1;
        chk("sweep_timeout", {31'd0, init_bsy_o}, 32'd0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: both requesters valid, nothing may be granted
        wr_val_i = 1'b1; rd_val_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cen", {31'd0, cen_o}, 32'd1);
        chk("rst_wen", {31'd0, wen_o}, 32'd1);
        chk("rst_wr_rdy", {31'd0, wr_rdy_o}, 32'd0);
        chk("rst_rd_rdy", {31'd0, rd_rdy_o}, 32'd0);
        chk("rst_rd_vld", {31'd0, rd_vld_o}, 32'd0);
        chk("rst_bsy", {31'd0, init_bsy_o}, 32'd0);
        chk("rst_done", {31'd0, init_done_o}, 32'd0);
        chk("oen", {31'd0, oen_o}, 32'd0);
        wr_val_i = 1'b0; rd_val_i = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Write then read back
        do_wr(8'h12, 20'hABCDE);
        do_rd(8'h12, 20'hABCDE);
        drain();

        // Both held for 4 cycles after reset: RD,WR,RD,WR
        apply_reset();
        wr_val_i = 1'b1; wr_adr_i = 8'h12; wr_dat_i = 20'h11111;
        rd_val_i = 1'b1; rd_adr_i = 8'h12;
        exp_acc.push_back(mk(1'b1, 8'h12, '0));
        exp_acc.push_back(mk(1'b0, 8'h12, 20'h11111));
        exp_acc.push_back(mk(1'b1, 8'h12, '0));
        exp_acc.push_back(mk(1'b0, 8'h12, 20'h11111));
        exp_rd.push_back(20'hABCDE);
        exp_rd.push_back(20'h11111);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_rd_rdy", {31'd0, rd_rdy_o}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_wr_rdy", {31'd0, wr_rdy_o}, (c % 2 == 0) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        wr_val_i = 1'b0; rd_val_i = 1'b0;
        drain();

        // Last grant was WR, so a fresh tie goes to RD; then lone WR twice in a row
        wr_val_i = 1'b1; wr_adr_i = 8'h34; wr_dat_i = 20'h0F0F0;
        do_rd(8'h12, 20'h11111);
        exp_acc.push_back(mk(1'b0, 8'h34, 20'h0F0F0));
        @(negedge clk);
        chk("tie_then_wr", {31'd0, wr_rdy_o}, 32'd1);
        @(posedge clk); #1;
        wr_val_i = 1'b0;
        do_wr(8'h35, 20'hFFFFF);
        do_rd(8'h34, 20'h0F0F0);
        do_rd(8'h35, 20'hFFFFF);
        drain();

`ifdef DB_RAM_ARB_INIT_EN
        begin
            int bad = 0;
            // Sweep; read accepted in the init_i cycle still completes
            rd_val_i = 1'b1; rd_adr_i = 8'h12; init_i = 1'b1;
            exp_acc.push_back(mk(1'b1, 8'h12, '0));
            exp_rd.push_back(20'h11111);
            push_sweep(256);
            exp_acc.push_back(mk(1'b0, 8'h05, 20'h33333));
            bsy_cnt = 0;
            @(negedge clk);
            chk("init_cycle_rd_rdy", {31'd0, rd_rdy_o}, 32'd1);
            @(posedge clk); #1;
            init_i = 1'b0; rd_val_i = 1'b0;
            wr_val_i = 1'b1; wr_adr_i = 8'h05; wr_dat_i = 20'h33333;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk);
                if (wr_rdy_o || !init_bsy_o) bad++;
            end
            chk("sweep_blocks_wr", bad, 32'd0);
            @(negedge clk);
            chk("done_cycle_wr_rdy", {31'd0, wr_rdy_o}, 32'd1);
            chk("done_pulse", {31'd0, init_done_o}, 32'd1);
            @(posedge clk); #1;
            wr_val_i = 1'b0;
            chk("sweep_len", bsy_cnt, 32'd256);
            do_rd(8'hFF, 20'h0);
            do_rd(8'h05, 20'h33333);
            drain();
            chk("done_cnt_1", done_cnt, 32'd1);

            // Re-pulse during the sweep is ignored
            init_i = 1'b1;
            push_sweep(256);
            bsy_cnt = 0;
            @(posedge clk); #1 init_i = 1'b0;
            repeat (99) @(posedge clk);
            #1 init_i = 1'b1;
            @(posedge clk); #1 init_i = 1'b0;
            wait_sweep_end();
            drain();
            chk("repulse_len", bsy_cnt, 32'd256);
            chk("done_cnt_2", done_cnt, 32'd2);

            // Reset at sweep cycle 50 aborts; a new pulse restarts at 0
            init_i = 1'b1;
            push_sweep(49);
            @(posedge clk); #1 init_i = 1'b0;
            repeat (49) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("abort_bsy", {31'd0, init_bsy_o}, 32'd0);
            chk("abort_acc", exp_acc.size(), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, 32'd2);
            init_i = 1'b1;
            push_sweep(256);
            @(posedge clk); #1 init_i = 1'b0;
            wait_sweep_end();
            drain();
            chk("done_cnt_3", done_cnt, 32'd3);
        end
`else
        // Without the sweep, init_i has no effect on arbitration
        rd_val_i = 1'b1; rd_adr_i = 8'h05; init_i = 1'b1;
        exp_acc.push_back(mk(1'b1, 8'h05, '0));
        exp_acc.push_back(mk(1'b1, 8'h05, '0));
        exp_rd.push_back(20'h0F0F0 ^ 20'h0F0F0 ^ mem[5]);
        exp_rd.push_back(mem[5]);
        @(negedge clk);
        chk("noinit_rd_rdy0", {31'd0, rd_rdy_o}, 32'd1);
        chk("noinit_bsy0", {31'd0, init_bsy_o}, 32'd0);
        @(posedge clk); #1 init_i = 1'b0;
        @(negedge clk);
        chk("noinit_rd_rdy1", {31'd0, rd_rdy_o}, 32'd1);
        chk("noinit_bsy1", {31'd0, init_bsy_o}, 32'd0);
        @(posedge clk); #1 rd_val_i = 1'b0;
        @(negedge clk);
        chk("noinit_rd_rdy_idle", {31'd0, rd_rdy_o}, 32'd0);
        drain();
        chk("noinit_done_cnt", done_cnt, 32'd0);
`endif

        // Reset landing on the result cycle suppresses rd_vld_o
        rd_val_i = 1'b1; rd_adr_i = 8'h12;
        exp_acc.push_back(mk(1'b1, 8'h12, '0));
        @(negedge clk);
        chk("pre_rst_rd_rdy", {31'd0, rd_rdy_o}, 32'd1);
        @(posedge clk); #1;
        rd_val_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_kills_rd_vld", {31'd0, rd_vld_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rd_vld", {31'd0, rd_vld_o}, 32'd0);
        chk("final_acc_q", exp_acc.size(), 32'd0);
        chk("final_rd_q", exp_rd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
